// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package shift_add_multiplier_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_add_multiplier_ripple_adder.sv
// 16-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module ripple_adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   always_comb begin
      // NOTE: blocking assignments here model the ripple chain; each bit sees
      // the carry just produced by the bit below it in the same evaluation.
      logic carry;
      carry = cin;
      sum   = '0;
      for (int i = 0; i < 16; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one ripple-adder pass per clock,
// WIDTH iterations per product, result held until the next accepted start.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   m;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               cout;

   assign addend = q[0] ? m : '0;

   // The adder is a fixed 16-bit block, so WIDTH must stay at 16 here.
   ripple_adder_16bit u_adder (
      .a    (acc),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   assign ready = (state == S_IDLE);
   assign busy  = (state == S_RUN);
   assign done  = (state == S_DONE);

   always_ff @(posedge clk) begin
      // NOTE: every sequential register uses non-blocking assignment so all
      // flops update together from pre-edge values.
      if (rst) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state <= S_RUN;
               count <= '0;
            end
            S_RUN: begin
               count <= count + CNT_W'(1);
               if (count == LAST_ITER) state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // The carry bit never needs its own register: it lands directly in the
   // ACC MSB on the shift, so nothing is ever dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         m       <= '0;
         q       <= '0;
         acc     <= '0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               m   <= a;
               q   <= b;
               acc <= '0;
            end
            S_RUN: begin
               acc <= {cout, sum[WIDTH-1:1]};
               q   <= {sum[0], q[WIDTH-1:1]};
               if (count == LAST_ITER) product <= {cout, sum, q[WIDTH-1:1]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed and random operands against a cycle-level
// behavioural model of the multiplier's handshake and product.
module tb_shift_add_multiplier;

   localparam int WIDTH = 16;

   logic              clk;
   logic              rst;
   logic              start;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              ready;
   logic              busy;
   logic              done;
   logic [2*WIDTH-1:0] product;

   int tests  = 0;
   int failed = 0;
   bit chk_on = 0;

   shift_add_multiplier #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase -1 idle, 0..WIDTH-1 iterating, WIDTH = result cycle.
   int                 phase = -1;
   logic [2*WIDTH-1:0] pend  = '0;
   logic [2*WIDTH-1:0] held  = '0;

   always @(posedge clk) begin
      if (rst) begin
         phase <= -1;
         held  <= '0;
      end else if (phase < 0) begin
         if (start) begin
            phase <= 0;
            pend  <= 32'(a) * 32'(b);
         end
      end else if (phase == WIDTH) begin
         phase <= -1;
      end else begin
         phase <= phase + 1;
         if (phase == WIDTH - 1) held <= pend;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("ready",   64'(ready),   64'(phase < 0));
         check("busy",    64'(busy),    64'(phase >= 0 && phase < WIDTH));
         check("done",    64'(done),    64'(phase == WIDTH));
         check("product", 64'(product), 64'(held));
         check("onehot",  64'($countones({ready, busy, done})), 64'd1);
      end
   end

   task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                        input logic [2*WIDTH-1:0] exp_p, input string name);
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready"}, 64'(ready), 64'd1);
      a = ta;
      b = tbv;
      start = 1;
      @(negedge clk);
      start = 0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, 64'(n), 64'(WIDTH));
      check({name, "_product"}, 64'(product), 64'(exp_p));
   endtask

   initial begin
      int n;
      logic [WIDTH-1:0] ra, rb;
      rst = 1;
      start = 0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      check("rst_product", 64'(product), 64'd0);
      check("rst_done",    64'(done),    64'd0);
      check("rst_busy",    64'(busy),    64'd0);
      check("rst_ready",   64'(ready),   64'd1);
      rst = 0;
      chk_on = 1;

      do_op(16'd5,      16'd9,      32'd45,         "basic");
      do_op(16'd111,    16'd41,     32'd4551,       "b2b_0");
      do_op(16'd15,     16'd9,      32'd135,        "b2b_1");
      do_op(16'd2,      16'd3,      32'd6,          "b2b_2");
      do_op(16'hFFFF,   16'hFFFF,   32'hFFFE0001,   "max");
      do_op(16'd0,      16'h1234,   32'd0,          "zero");
      do_op(16'd1,      16'h8000,   32'h00008000,   "msb");

      // start held high through RUN with operands changing underneath
      while (!ready) @(negedge clk);
      a = 16'd7;
      b = 16'd11;
      start = 1;
      n = 0;
      do begin
         @(negedge clk);
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         n++;
      end while (!done && n < 40);
      start = 0;
      check("held_start_product", 64'(product), 64'd77);
      @(negedge clk);
      @(negedge clk);
      check("held_start_single_done", 64'(done), 64'd0);

      // reset in the middle of an operation
      while (!ready) @(negedge clk);
      a = 16'd300;
      b = 16'd200;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (8) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("abort_ready",   64'(ready),   64'd1);
      check("abort_product", 64'(product), 64'd0);
      repeat (20) @(negedge clk);
      check("abort_no_done", 64'(done),    64'd0);
      do_op(16'd300, 16'd200, 32'd60000, "after_abort");

      for (int i = 0; i < 20; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(ra, rb, 32'(ra) * 32'(rb), "random");
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
